// File: rtl/sound_mix_sched_pkg.sv
// Shared types and constants for the Soundrive/Covox mixer/scheduler.
package sound_mix_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L0,
    L1,
    LB,
    R0,
    R1,
    RB
  } mix_state_t;

  localparam logic [9:0] MIX_MID = 10'd256;

endpackage

// File: rtl/sound_pdm_mod.sv
// Single-channel first-order sigma-delta modulator, 10-bit unsigned input.
module sound_pdm_mod (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic       pdm
);

  logic [9:0]  acc10;
  logic [10:0] sum;

  // Carry out of the 10-bit accumulator is the output bit.
  assign sum = {1'b0, acc10} + {1'b0, din};

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      acc10 <= '0;
      pdm   <= 1'b0;
    end else begin
      acc10 <= sum[9:0];
      pdm   <= sum[10];
    end
  end

endmodule

// File: rtl/sound_mix_sched.sv
// Time-multiplexed DAC channel + beeper mixer with a shared 10-bit accumulator.
// Optional PDM outputs are built when SOUND_MIX_PDM_EN is defined.
module sound_mix_sched
  import sound_mix_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 640,
  parameter int unsigned BEEPER_AMP = 64
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       en,
  input  logic       beeper,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  output logic [9:0] out_l,
  output logic [9:0] out_r,
  output logic       sample_valid,
  output logic       overrun,
  output logic       pdm_l,
  output logic       pdm_r
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [9:0]  BEEP_VAL = 10'(BEEPER_AMP);

  logic [15:0] div_cnt;
  logic        tick;
  mix_state_t  state;
  logic [9:0]  acc;
  logic [7:0]  s_l0, s_l1, s_r0, s_r1;
  logic        s_beep, s_en;
  logic [9:0]  beep_term;
  logic [9:0]  mix_sum;

  assign tick      = (div_cnt == DIV_LAST);
  assign beep_term = s_beep ? BEEP_VAL : '0;
  assign mix_sum   = acc + beep_term;

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      state        <= IDLE;
      acc          <= '0;
      s_l0         <= '0;
      s_l1         <= '0;
      s_r0         <= '0;
      s_r1         <= '0;
      s_beep       <= 1'b0;
      s_en         <= 1'b0;
      out_l        <= MIX_MID;
      out_r        <= MIX_MID;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 16'd1;
      sample_valid <= 1'b0;
      // A tick during a sequence is dropped; only the sticky flag records it.
      if (tick && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick) begin
            s_l0   <= ch_l0;
            s_l1   <= ch_l1;
            s_r0   <= ch_r0;
            s_r1   <= ch_r1;
            s_beep <= beeper;
            s_en   <= en;
            state  <= L0;
          end
        end
        L0: begin
          acc   <= {2'b00, s_l0};
          state <= L1;
        end
        L1: begin
          acc   <= acc + {2'b00, s_l1};
          state <= LB;
        end
        LB: begin
          out_l <= s_en ? mix_sum : MIX_MID;
          state <= R0;
        end
        R0: begin
          acc   <= {2'b00, s_r0};
          state <= R1;
        end
        R1: begin
          acc   <= acc + {2'b00, s_r1};
          state <= RB;
        end
        RB: begin
          out_r        <= s_en ? mix_sum : MIX_MID;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SOUND_MIX_PDM_EN
  sound_pdm_mod u_pdm_l (
    .clk28 (clk28),
    .rst_n (rst_n),
    .din   (out_l),
    .pdm   (pdm_l)
  );

  sound_pdm_mod u_pdm_r (
    .clk28 (clk28),
    .rst_n (rst_n),
    .din   (out_r),
    .pdm   (pdm_r)
  );
`else
  assign pdm_l = 1'b0;
  assign pdm_r = 1'b0;
`endif

endmodule

// File: tb/tb_sound_mix_sched.sv
// Randomized bench for sound_mix_sched against a sample-schedule reference model.
module tb_sound_mix_sched;

  localparam int DIV  = 16;
  localparam int AMP  = 64;
  localparam int ODIV = 4;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       beeper = 1'b0;
  logic [7:0] ch_l0 = 8'h80, ch_l1 = 8'h80, ch_r0 = 8'h80, ch_r1 = 8'h80;
  logic [9:0] out_l, out_r;
  logic       sample_valid, overrun, pdm_l, pdm_r;

  logic [9:0] o_out_l, o_out_r;
  logic       o_valid, o_overrun, o_pdm_l, o_pdm_r;

  int checks = 0;
  int errors = 0;

  always #5 clk28 = ~clk28;

  sound_mix_sched #(.SAMPLE_DIV(DIV), .BEEPER_AMP(AMP)) u_dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .en           (en),
    .beeper       (beeper),
    .ch_l0        (ch_l0),
    .ch_l1        (ch_l1),
    .ch_r0        (ch_r0),
    .ch_r1        (ch_r1),
    .out_l        (out_l),
    .out_r        (out_r),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .pdm_l        (pdm_l),
    .pdm_r        (pdm_r)
  );

  // Divider shorter than the 7-state sequence, so ticks land while busy.
  sound_mix_sched #(.SAMPLE_DIV(ODIV), .BEEPER_AMP(AMP)) u_ovr (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .en           (1'b1),
    .beeper       (1'b0),
    .ch_l0        (8'h10),
    .ch_l1        (8'h20),
    .ch_r0        (8'h30),
    .ch_r1        (8'h40),
    .out_l        (o_out_l),
    .out_r        (o_out_r),
    .sample_valid (o_valid),
    .overrun      (o_overrun),
    .pdm_l        (o_pdm_l),
    .pdm_r        (o_pdm_r)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: edge e (counted from reset release) is a tick when
  // e % DIV == 0; inputs at that edge give out_l three edges later and
  // out_r plus a one-cycle valid six edges later.
  int edge_n = 0;
  int pl_at = -1, pr_at = -1;
  int pend_l = 256, pend_r = 256;
  int m_l = 256, m_r = 256, m_v = 0;

  always @(posedge clk28) begin : model
    int e;
    if (!rst_n) begin
      edge_n <= 0;
      m_l    <= 256;
      m_r    <= 256;
      m_v    <= 0;
      pl_at  <= -1;
      pr_at  <= -1;
    end else begin
      e = edge_n + 1;
      edge_n <= e;
      m_v    <= 0;
      if (e == pl_at) m_l <= pend_l;
      if (e == pr_at) begin
        m_r <= pend_r;
        m_v <= 1;
      end
      if (e % DIV == 0) begin
        pend_l <= en ? (int'(ch_l0) + int'(ch_l1) + (beeper ? AMP : 0)) : 256;
        pend_r <= en ? (int'(ch_r0) + int'(ch_r1) + (beeper ? AMP : 0)) : 256;
        pl_at  <= e + 3;
        pr_at  <= e + 6;
      end
    end
  end

  always @(negedge clk28) begin
    chk("out_l", int'(out_l), m_l);
    chk("out_r", int'(out_r), m_r);
    chk("valid", int'(sample_valid), m_v);
    chk("overrun", int'(overrun), 0);
  end

  task automatic wait_valid();
    bit got = 1'b0;
    for (int i = 0; i < 4 * DIV && !got; i++) begin
      @(negedge clk28);
      got = sample_valid;
    end
    if (!got) chk("valid_timeout", 0, 1);
  endtask

  task automatic set_ch(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    ch_l0 = a;
    ch_l1 = b;
    ch_r0 = c;
    ch_r1 = d;
  endtask

  initial begin
    int n_ovr;
    int ones_l, ones_r;

    rst_n = 1'b0;
    repeat (3) @(negedge clk28);
    chk("rst_out_l", int'(out_l), 256);
    chk("rst_out_r", int'(out_r), 256);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pdm_l", int'(pdm_l), 0);
    chk("rst_pdm_r", int'(pdm_r), 0);
    chk("rst_ovr_flag", int'(o_overrun), 0);
    rst_n = 1'b1;

    // Idle midpoint, first tick timing and the overrun instance
    n_ovr = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk28);
      if (o_valid) n_ovr++;
      if (i == 7)  chk("ovr_before", int'(o_overrun), 0);
      if (i == 8)  chk("ovr_set", int'(o_overrun), 1);
      if (i == 21) chk("first_valid_early", int'(sample_valid), 0);
      if (i == 22) begin
        chk("first_valid", int'(sample_valid), 1);
        chk("idle_mid_l", int'(out_l), 256);
        chk("idle_mid_r", int'(out_r), 256);
      end
    end
    chk("ovr_pulses", n_ovr, 4);
    chk("ovr_out_l", int'(o_out_l), 48);
    chk("ovr_out_r", int'(o_out_r), 112);
    chk("ovr_sticky", int'(o_overrun), 1);

    // Full-scale left plus beeper, silent right
    set_ch(8'hFF, 8'hFF, 8'h00, 8'h00);
    beeper = 1'b1;
    wait_valid();
    wait_valid();
    chk("max_l", int'(out_l), 574);
    chk("max_r", int'(out_r), 64);

    // Snapshot coherence: change ch_l0 one edge after the snapshot
    set_ch(8'h10, 8'h00, 8'h80, 8'h80);
    beeper = 1'b0;
    wait_valid();
    wait_valid();
    repeat (DIV - 5) @(negedge clk28);
    ch_l0 = 8'hF0;
    wait_valid();
    chk("snap_old", int'(out_l), 16);
    wait_valid();
    chk("snap_new", int'(out_l), 240);

    // Mute, then PDM density over a held midpoint
    en = 1'b0;
    set_ch(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    beeper = 1'b1;
    wait_valid();
    wait_valid();
    chk("mute_l", int'(out_l), 256);
    chk("mute_r", int'(out_r), 256);
    ones_l = 0;
    ones_r = 0;
    repeat (1024) begin
      @(negedge clk28);
      ones_l += int'(pdm_l);
      ones_r += int'(pdm_r);
    end
`ifdef SOUND_MIX_PDM_EN
    chk("pdm_density_l", ones_l, 256);
    chk("pdm_density_r", ones_r, 256);
`else
    chk("pdm_off_l", ones_l, 0);
    chk("pdm_off_r", ones_r, 0);
`endif
    en = 1'b1;

    // Random traffic with two resets dropped in mid-stream
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk28);
      rst_n = !(i == 1500 || i == 2203);
      if ($urandom_range(3) == 0) begin
        set_ch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        beeper = 1'($urandom);
        en = ($urandom_range(4) != 0);
      end
    end

    @(negedge clk28);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
